// File: rtl/io_bus_fabric.sv
// Byte-lane I/O bus fabric: NUM_SLOTS uniform 8-byte peripheral windows plus a
// sticky bus-error register block, with unaligned 16-bit access support.
module io_bus_fabric #(
    parameter int          NUM_SLOTS   = 6,
    parameter logic [15:0] SLOT_BASE   = 16'h0010,
    parameter int          SLOT_STRIDE = 8,
    parameter logic [15:0] ERR_BASE    = 16'h0008,
    parameter logic [15:0] IO_LIMIT    = 16'h0080
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               dread_addr,
    output logic [15:0]               dread_data,
    input  logic [15:0]               dwrite_addr,
    input  logic [15:0]               dwrite_data,
    input  logic [1:0]                dwrite_en,
    output logic [NUM_SLOTS*8-1:0]    slot_wr_strb,
    output logic [7:0]                slot_wr_even,
    output logic [7:0]                slot_wr_odd,
    input  logic [NUM_SLOTS*64-1:0]   slot_rd_data,
    output logic                      bus_err
);

    typedef struct packed {
        logic       slot;
        logic       err;
        logic [3:0] idx;
        logic [2:0] k;
        logic [1:0] eoff;
    } dec_t;

    // Decodes one byte address; anything at or above IO_LIMIT decodes to nothing.
    function automatic dec_t decode(input logic [15:0] a);
        dec_t        d;
        logic [16:0] off;
        d = '0;
        if (a < IO_LIMIT) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                off = {1'b0, a} - 17'(SLOT_BASE + i * SLOT_STRIDE);
                if (off < 17'd8) begin
                    d.slot = 1'b1;
                    d.idx  = 4'(i);
                    d.k    = off[2:0];
                end
            end
            off = {1'b0, a} - {1'b0, ERR_BASE};
            if (off < 17'd4) begin
                d.err  = 1'b1;
                d.eoff = off[1:0];
            end
        end
        return d;
    endfunction

    logic        err;
    logic        ovf;
    logic [15:0] err_addr;

    logic [15:0] wa [2];
    logic [15:0] ra [2];
    logic [7:0]  wb [2];
    logic        we [2];
    dec_t        wd [2];
    dec_t        rdd [2];
    logic [7:0]  rb [2];

    logic        err_n;
    logic        ovf_n;
    logic [15:0] err_addr_n;

    // Byte 0 is the addressed byte, byte 1 the next address (wraps at 16'hFFFF).
    always_comb begin
        wa[0] = dwrite_addr;
        wa[1] = dwrite_addr + 16'd1;
        ra[0] = dread_addr;
        ra[1] = dread_addr + 16'd1;
        wb[0] = dwrite_data[7:0];
        wb[1] = dwrite_data[15:8];
        we[0] = dwrite_en[0] && !reset;
        we[1] = dwrite_en[1] && !reset;
        for (int b = 0; b < 2; b++) begin
            wd[b]  = decode(wa[b]);
            rdd[b] = decode(ra[b]);
        end
    end

    assign slot_wr_even = dwrite_addr[0] ? dwrite_data[15:8] : dwrite_data[7:0];
    assign slot_wr_odd  = dwrite_addr[0] ? dwrite_data[7:0]  : dwrite_data[15:8];

    always_comb begin
        slot_wr_strb = '0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                for (int k = 0; k < 8; k++) begin
                    if (we[b] && wd[b].slot && wd[b].idx == 4'(i) && wd[b].k == 3'(k))
                        slot_wr_strb[i*8+k] = 1'b1;
                end
            end
        end
    end

    // Slot reads forward same-cycle write bytes; ERR block reads see current state.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rb[b] = 8'h00;
            if (rdd[b].slot) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        if (rdd[b].idx == 4'(i) && rdd[b].k == 3'(k))
                            rb[b] = slot_rd_data[i*64+k*8 +: 8];
                    end
                end
                for (int w = 0; w < 2; w++) begin
                    if (we[w] && wd[w].slot && wa[w] == ra[b])
                        rb[b] = wb[w];
                end
            end else if (rdd[b].err) begin
                case (rdd[b].eoff)
                    2'd0:    rb[b] = {6'b0, ovf, err};
                    2'd1:    rb[b] = 8'h00;
                    2'd2:    rb[b] = err_addr[7:0];
                    default: rb[b] = err_addr[15:8];
                endcase
            end
        end
    end

    // W1C clears apply first so a coincident new error is captured as a fresh one.
    always_comb begin
        err_n      = err;
        ovf_n      = ovf;
        err_addr_n = err_addr;
        for (int b = 0; b < 2; b++) begin
            if (we[b] && wd[b].err && wd[b].eoff == 2'd0) begin
                if (wb[b][0]) err_n = 1'b0;
                if (wb[b][1]) ovf_n = 1'b0;
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (we[b] && wa[b] < IO_LIMIT && !wd[b].slot && !wd[b].err) begin
                if (!err_n) begin
                    err_n      = 1'b1;
                    err_addr_n = wa[b];
                end else begin
                    ovf_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dread_data <= 16'h0000;
            err        <= 1'b0;
            ovf        <= 1'b0;
            err_addr   <= 16'h0000;
        end else begin
            dread_data <= {rb[1], rb[0]};
            err        <= err_n;
            ovf        <= ovf_n;
            err_addr   <= err_addr_n;
        end
    end

    assign bus_err = err;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric: vector table for lane/strobe/read behaviour,
// hand-written sequences for error capture, W1C and reset.
module tb_io_bus_fabric;

    localparam int NS = 6;

    logic             clk;
    logic             reset;
    logic [15:0]      dread_addr;
    logic [15:0]      dread_data;
    logic [15:0]      dwrite_addr;
    logic [15:0]      dwrite_data;
    logic [1:0]       dwrite_en;
    logic [NS*8-1:0]  slot_wr_strb;
    logic [7:0]       slot_wr_even;
    logic [7:0]       slot_wr_odd;
    logic [NS*64-1:0] slot_rd_data;
    logic             bus_err;

    int checks;
    int failures;

    io_bus_fabric dut (
        .clk          (clk),
        .reset        (reset),
        .dread_addr   (dread_addr),
        .dread_data   (dread_data),
        .dwrite_addr  (dwrite_addr),
        .dwrite_data  (dwrite_data),
        .dwrite_en    (dwrite_en),
        .slot_wr_strb (slot_wr_strb),
        .slot_wr_even (slot_wr_even),
        .slot_wr_odd  (slot_wr_odd),
        .slot_rd_data (slot_rd_data),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [1:0]  wen;
        logic [15:0] raddr;
        logic [47:0] strb;
        logic [7:0]  even;
        logic [7:0]  odd;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we,
                         input logic [15:0] ra);
        dwrite_addr = wa;
        dwrite_data = wd;
        dwrite_en   = we;
        dread_addr  = ra;
    endtask

    // One bus cycle; returns sampled just after the edge.
    task automatic cyc(input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we,
                       input logic [15:0] ra);
        drive(wa, wd, we, ra);
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input string name, input logic [15:0] ra, input logic [15:0] exp);
        cyc(16'h0000, 16'h0000, 2'b00, ra);
        chk(name, 64'(dread_data), 64'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        for (int i = 0; i < NS; i++)
            for (int k = 0; k < 8; k++)
                slot_rd_data[i*64+k*8 +: 8] = 8'(8'h40 + i * 8 + k);
        slot_rd_data[7*8 +: 8] = 8'hAA;
        slot_rd_data[64 +: 8]  = 8'h55;

        //          waddr     wdata     wen    raddr     strb                 even   odd    rdata
        vecs[0] = '{16'h0012, 16'hBEEF, 2'b11, 16'h0017, 48'h0000_0000_000C, 8'hEF, 8'hBE, 16'h55AA};
        vecs[1] = '{16'h0013, 16'h1234, 2'b11, 16'h0020, 48'h0000_0000_0018, 8'h12, 8'h34, 16'h5150};
        vecs[2] = '{16'h0010, 16'h0077, 2'b01, 16'h0010, 48'h0000_0000_0001, 8'h77, 8'h00, 16'h4177};
        vecs[3] = '{16'h003F, 16'hCDAB, 2'b01, 16'h003F, 48'h8000_0000_0000, 8'hCD, 8'hAB, 16'h00AB};
        vecs[4] = '{16'h0080, 16'h1111, 2'b11, 16'h000F, 48'h0000_0000_0000, 8'h11, 8'h11, 16'h4000};
        vecs[5] = '{16'hFFFF, 16'h2233, 2'b01, 16'hFFFF, 48'h0000_0000_0000, 8'h22, 8'h33, 16'h0000};
        vecs[6] = '{16'h0014, 16'hFFFF, 2'b00, 16'h0014, 48'h0000_0000_0000, 8'hFF, 8'hFF, 16'h4544};
        vecs[7] = '{16'h0027, 16'h9988, 2'b10, 16'h0027, 48'h0000_0100_0000, 8'h99, 8'h88, 16'h9957};
        vecs[8] = '{16'h0050, 16'h0000, 2'b00, 16'h0008, 48'h0000_0000_0000, 8'h00, 8'h00, 16'h0000};

        // Reset with a live slot write: no strobe, registers cleared.
        reset = 1'b1;
        drive(16'h0012, 16'hBEEF, 2'b11, 16'h0012);
        @(negedge clk);
        chk("reset_strb", 64'(slot_wr_strb), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_rdata", 64'(dread_data), 64'h0);
        chk("reset_err", 64'(bus_err), 64'h0);
        reset = 1'b0;
        cyc(16'h0000, 16'h0000, 2'b00, 16'h0000);

        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].waddr, vecs[v].wdata, vecs[v].wen, vecs[v].raddr);
            @(negedge clk);
            chk($sformatf("vec%0d_strb", v), 64'(slot_wr_strb), 64'(vecs[v].strb));
            chk($sformatf("vec%0d_even", v), 64'(slot_wr_even), 64'(vecs[v].even));
            chk($sformatf("vec%0d_odd", v), 64'(slot_wr_odd), 64'(vecs[v].odd));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rdata", v), 64'(dread_data), 64'(vecs[v].rdata));
            chk($sformatf("vec%0d_err", v), 64'(bus_err), 64'h0);
            drive(16'h0000, 16'h0000, 2'b00, 16'h0000);
        end

        // First unmapped write latches address.
        drive(16'h0004, 16'h00AA, 2'b01, 16'h0000);
        @(negedge clk);
        chk("unmapped_strb", 64'(slot_wr_strb), 64'h0);
        @(posedge clk); #1;
        chk("err1_bus_err", 64'(bus_err), 64'h1);
        read_reg("err1_status", 16'h0008, 16'h0001);
        read_reg("err1_addr", 16'h000A, 16'h0004);

        // Second unmapped write sets overflow, address held.
        cyc(16'h0005, 16'h0000, 2'b01, 16'h0000);
        read_reg("ovf_status", 16'h0008, 16'h0003);
        read_reg("ovf_addr", 16'h000A, 16'h0004);

        // W1C of both bits coincident with a new unmapped byte; read sees old state.
        cyc(16'h0007, 16'h0300, 2'b11, 16'h0008);
        chk("w1c_pre_read", 64'(dread_data), 64'h0003);
        read_reg("w1c_set_status", 16'h0008, 16'h0001);
        read_reg("w1c_set_addr", 16'h000A, 16'h0007);

        // Plain W1C clear, then writes to read-only bytes are ignored.
        cyc(16'h0008, 16'h0001, 2'b01, 16'h0000);
        chk("w1c_clear", 64'(bus_err), 64'h0);
        cyc(16'h000A, 16'hFFFF, 2'b11, 16'h0000);
        chk("ro_write_err", 64'(bus_err), 64'h0);
        read_reg("ro_write_addr", 16'h000A, 16'h0007);

        // Both bytes unmapped in one write.
        cyc(16'h0000, 16'h5A5A, 2'b11, 16'h0000);
        read_reg("both_status", 16'h0008, 16'h0003);
        read_reg("both_addr", 16'h000A, 16'h0000);

        // Reset during an unmapped write drops it and clears error state.
        reset = 1'b1;
        cyc(16'h0004, 16'h0000, 2'b01, 16'h0017);
        chk("midreset_err", 64'(bus_err), 64'h0);
        chk("midreset_rdata", 64'(dread_data), 64'h0);
        reset = 1'b0;
        read_reg("midreset_status", 16'h0008, 16'h0000);
        read_reg("midreset_addr", 16'h000A, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
